// File: rtl/aes_kat_pkg.sv
// Purpose: shared types, FIPS-197 Appendix C vectors and helpers for the AES KAT sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_kat_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_NEXT,
        S_FINISH
    } state_t;

    localparam int NUM_TESTS = 6;

    // Test index: bit 0 selects decrypt, bits [2:1] select key size.
    localparam logic [2:0] T_ENC128 = 3'd0;
    localparam logic [2:0] T_DEC128 = 3'd1;
    localparam logic [2:0] T_ENC192 = 3'd2;
    localparam logic [2:0] T_DEC192 = 3'd3;
    localparam logic [2:0] T_ENC256 = 3'd4;
    localparam logic [2:0] T_DEC256 = 3'd5;

    localparam logic [1:0] KL128 = 2'b10;
    localparam logic [1:0] KL192 = 2'b01;
    localparam logic [1:0] KL256 = 2'b11;

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY128 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [191:0] KEY192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    // Lowest enabled test index >= lo; returns {found, index}.
    function automatic logic [3:0] find_enabled(input logic [5:0] mask, input logic [3:0] lo);
        logic [3:0] r;
        r = '0;
        for (int i = NUM_TESTS - 1; i >= 0; i--) begin
            if (mask[i] && (4'(i) >= lo)) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_kat_sequencer_if.sv
// Purpose: start/done handshake and data buses between the KAT sequencer and the AES core.
// Latency: n/a (wiring only).
// Backpressure: none; the core answers with a one-cycle core_done pulse.
interface aes_kat_sequencer_if;
    logic         core_start;
    logic         core_decrypt;
    logic [1:0]   core_key_len;
    logic [255:0] core_key;
    logic [127:0] core_din;
    logic         core_done;
    logic [127:0] core_dout;

    modport master (
        output core_start, core_decrypt, core_key_len, core_key, core_din,
        input  core_done, core_dout
    );

    modport slave (
        input  core_start, core_decrypt, core_key_len, core_key, core_din,
        output core_done, core_dout
    );
endinterface

// File: rtl/aes_kat_rom.sv
// Purpose: combinational vector lookup, test index -> {decrypt, key_len, key, din, expected}.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module aes_kat_rom
    import aes_kat_pkg::*;
(
    input  logic [2:0]   idx,
    output logic         decrypt,
    output logic [1:0]   key_len,
    output logic [255:0] key,
    output logic [127:0] din,
    output logic [127:0] expected
);

    logic [127:0] ct;
    logic         valid;

    // Pick key and ciphertext by key size; decrypt tests swap input and expected blocks.
    always_comb begin
        decrypt  = 1'b0;
        key_len  = '0;
        key      = '0;
        din      = '0;
        expected = '0;
        ct       = '0;
        valid    = 1'b1;
        case (idx[2:1])
            2'd0: begin key_len = KL128; key = {KEY128, 128'h0}; ct = CT128; end
            2'd1: begin key_len = KL192; key = {KEY192, 64'h0};  ct = CT192; end
            2'd2: begin key_len = KL256; key = KEY256;           ct = CT256; end
            default: valid = 1'b0;
        endcase
        if (valid) begin
            decrypt  = idx[0];
            din      = idx[0] ? ct : PT;
            expected = idx[0] ? PT : ct;
        end
    end

endmodule

// File: rtl/aes_kat_sequencer.sv
// Purpose: runs the enabled FIPS-197 known-answer tests on one AES core and records pass/fail/timeout.
// Latency: L+3 cycles per test for core latency L (TIMEOUT_CYCLES+2 on timeout), done one cycle after the last test.
// Backpressure: start ignored while a run is in progress; core_done ignored outside the wait state.
module aes_kat_sequencer
    import aes_kat_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W           = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  test_en,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [5:0]  fail_vec,
    output logic [5:0]  timeout_vec,
    output logic [2:0]  cur_test,
    aes_kat_sequencer_if.master core
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state, state_d;
    logic [5:0]      mask_q;
    logic [2:0]      cur_q;
    logic [5:0]      fail_q;
    logic [5:0]      tmo_q;
    logic            pass_q;
    logic [TO_W-1:0] to_cnt;
    logic [127:0]    dout_q;

    logic            accept;
    logic            to_last;
    logic            drive;
    logic [3:0]      first_idx;
    logic [3:0]      next_idx;

    logic            rom_dec;
    logic [1:0]      rom_kl;
    logic [255:0]    rom_key;
    logic [127:0]    rom_din;
    logic [127:0]    rom_exp;

    aes_kat_rom u_rom (
        .idx      (cur_q),
        .decrypt  (rom_dec),
        .key_len  (rom_kl),
        .key      (rom_key),
        .din      (rom_din),
        .expected (rom_exp)
    );

    assign first_idx = find_enabled(test_en, 4'd0);
    assign next_idx  = find_enabled(mask_q, {1'b0, cur_q} + 4'd1);
    assign to_last   = (to_cnt == TO_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    // Next-state decode and state-derived controls.
    always_comb begin
        state_d = state;
        accept  = 1'b0;
        drive   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && (test_en != '0)) begin
                    accept  = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                drive   = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                drive = 1'b1;
                // core_done on the limit cycle wins over the timeout.
                if (core.core_done)  state_d = S_CHECK;
                else if (to_last)    state_d = S_NEXT;
            end
            S_CHECK:  state_d = S_NEXT;
            S_NEXT:   state_d = next_idx[3] ? S_ISSUE : S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Run bookkeeping: mask latch, current test, result capture, status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
            cur_q  <= '0;
            fail_q <= '0;
            tmo_q  <= '0;
            pass_q <= 1'b0;
            to_cnt <= '0;
            dout_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mask_q <= test_en;
                        cur_q  <= first_idx[2:0];
                        fail_q <= '0;
                        tmo_q  <= '0;
                        pass_q <= 1'b0;
                    end
                end
                S_ISSUE: to_cnt <= '0;
                S_WAIT: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (core.core_done) dout_q <= core.core_dout;
                    else if (to_last)   tmo_q[cur_q] <= 1'b1;
                end
                S_CHECK: begin
                    if (dout_q != rom_exp) fail_q[cur_q] <= 1'b1;
                end
                S_NEXT: begin
                    // Flags are final here, so pass is valid alongside the done pulse.
                    if (next_idx[3]) begin
                        cur_q <= next_idx[2:0];
                    end else begin
                        cur_q  <= '0;
                        pass_q <= ((fail_q | tmo_q) == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state != S_IDLE) && (state != S_FINISH);
    assign done        = (state == S_FINISH);
    assign pass        = pass_q;
    assign fail_vec    = fail_q;
    assign timeout_vec = tmo_q;
    assign cur_test    = cur_q;

    // Core request is only presented from issue until the wait ends.
    assign core.core_start   = (state == S_ISSUE);
    assign core.core_decrypt = drive & rom_dec;
    assign core.core_key_len = drive ? rom_kl  : '0;
    assign core.core_key     = drive ? rom_key : '0;
    assign core.core_din     = drive ? rom_din : '0;

endmodule

// File: tb/tb_aes_kat_sequencer.sv
// Purpose: scoreboard bench for aes_kat_sequencer with a behavioural AES core stand-in.
// Latency: per-run done cycle predicted from core latency and timeouts.
// Backpressure: exercises ignored starts and ignored core_done.
module tb_aes_kat_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  test_en;
    logic        busy, done, pass;
    logic [5:0]  fail_vec, timeout_vec;
    logic [2:0]  cur_test;

    aes_kat_sequencer_if cif ();

    aes_kat_sequencer #(.TIMEOUT_CYCLES(64), .TO_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .test_en     (test_en),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .fail_vec    (fail_vec),
        .timeout_vec (timeout_vec),
        .cur_test    (cur_test),
        .core        (cif)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Independent copy of the FIPS-197 Appendix C vectors, indexed by key size 0/1/2.
    logic [127:0] pt_v = 128'h00112233445566778899aabbccddeeff;
    logic [255:0] key_v [3];
    logic [127:0] ct_v  [3];
    logic [1:0]   kl_v  [3];

    initial begin
        key_v[0] = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        key_v[1] = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
        key_v[2] = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        ct_v[0]  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        ct_v[1]  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        ct_v[2]  = 128'h8ea2b7ca516745bfeafc49904b496089;
        kl_v[0]  = 2'b10;
        kl_v[1]  = 2'b01;
        kl_v[2]  = 2'b11;
    end

    // Core behaviour knobs; 99 means "no test affected".
    int lat         = 20;
    int corrupt_idx = 99;
    int silent_idx  = 99;

    typedef struct {
        logic [5:0] fv;
        logic [5:0] tv;
        logic       p;
        int         dc;
    } exp_t;

    int   start_q [$];
    exp_t res_q   [$];

    // AES core stand-in: answers known vectors after 'lat' cycles.
    initial begin : core_model
        int           sz;
        int           tix;
        logic [127:0] r;
        cif.core_done = 1'b0;
        cif.core_dout = '0;
        forever begin
            @(negedge clk);
            if (cif.core_start === 1'b1) begin
                sz = -1;
                for (int k = 0; k < 3; k++)
                    if (cif.core_key_len == kl_v[k] && cif.core_key == key_v[k]) sz = k;
                r   = 128'hbad0bad0bad0bad0bad0bad0bad0bad0;
                tix = -1;
                if (sz >= 0) begin
                    tix = sz * 2 + int'(cif.core_decrypt);
                    if (!cif.core_decrypt && cif.core_din == pt_v)       r = ct_v[sz];
                    else if (cif.core_decrypt && cif.core_din == ct_v[sz]) r = pt_v;
                end
                if (tix == corrupt_idx) r[0] = ~r[0];
                if (tix != silent_idx) begin
                    repeat (lat) @(posedge clk);
                    #1;
                    cif.core_done = 1'b1;
                    cif.core_dout = r;
                    @(posedge clk);
                    #1;
                    cif.core_done = 1'b0;
                end
            end
        end
    end

    // Monitor: every core_start must match the next expected test.
    initial begin : start_mon
        int idx;
        forever begin
            @(negedge clk);
            if (cif.core_start === 1'b1) begin
                if (start_q.size() == 0) begin
                    chk("unexpected core_start", {253'h0, cur_test}, 256'h1ff);
                end else begin
                    idx = start_q.pop_front();
                    chk("start cur_test", cur_test, idx);
                    chk("start decrypt", cif.core_decrypt, idx % 2);
                    chk("start key_len", cif.core_key_len, kl_v[idx / 2]);
                    chk("start key", cif.core_key, key_v[idx / 2]);
                    chk("start din", cif.core_din, (idx % 2) ? ct_v[idx / 2] : pt_v);
                end
            end
        end
    end

    // Monitor: every done must match the next expected run result and timing.
    initial begin : done_mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (res_q.size() == 0) begin
                    chk("unexpected done", {255'h0, done}, 256'h0);
                end else begin
                    e = res_q.pop_front();
                    chk("done pass", pass, e.p);
                    chk("done fail_vec", fail_vec, e.fv);
                    chk("done timeout_vec", timeout_vec, e.tv);
                    chk("done cycle", cyc, e.dc);
                    chk("done busy low", busy, 1'b0);
                    chk("done cur_test", cur_test, 3'd0);
                end
            end
        end
    end

    // Reference model for one run: push expected starts and the expected final result.
    task automatic expect_run(input logic [5:0] m, input int t0);
        exp_t e;
        int   dur;
        e.fv = '0;
        e.tv = '0;
        dur  = 0;
        for (int i = 0; i < 6; i++) begin
            if (m[i]) begin
                start_q.push_back(i);
                if (i == silent_idx) begin
                    e.tv[i] = 1'b1;
                    dur += 64 + 2;
                end else begin
                    if (i == corrupt_idx) e.fv[i] = 1'b1;
                    dur += lat + 3;
                end
            end
        end
        e.p  = ((e.fv | e.tv) == 0);
        e.dc = t0 + dur + 1;
        res_q.push_back(e);
    endtask

    task automatic pulse_start(input logic [5:0] m, input bit expect_it);
        @(posedge clk);
        #1;
        start   = 1'b1;
        test_en = m;
        if (expect_it) expect_run(m, cyc);
        @(posedge clk);
        #1;
        start   = 1'b0;
        test_en = 6'($urandom);
    endtask

    task automatic wait_idle(input string name);
        int waited;
        waited = 0;
        while ((res_q.size() != 0 || start_q.size() != 0) && waited < 3000) begin
            @(posedge clk);
            waited++;
        end
        chk(name, (waited < 3000) ? 1 : 0, 1);
        repeat (3) @(posedge clk);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, " busy"}, busy, 1'b0);
        chk({name, " done"}, done, 1'b0);
        chk({name, " pass"}, pass, 1'b0);
        chk({name, " fail_vec"}, fail_vec, 6'h0);
        chk({name, " timeout_vec"}, timeout_vec, 6'h0);
        chk({name, " cur_test"}, cur_test, 3'h0);
        chk({name, " core_start"}, cif.core_start, 1'b0);
        chk({name, " core_decrypt"}, cif.core_decrypt, 1'b0);
        chk({name, " core_key_len"}, cif.core_key_len, 2'b00);
        chk({name, " core_key"}, cif.core_key, 256'h0);
        chk({name, " core_din"}, cif.core_din, 128'h0);
    endtask

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: simulation did not reach its end, checks %0d errors %0d", n_checks, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int found;
        rst     = 1'b1;
        start   = 1'b0;
        test_en = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full run, ideal core, latency 20.
        lat = 20; corrupt_idx = 99; silent_idx = 99;
        pulse_start(6'h3F, 1'b1);
        @(negedge clk);
        chk("busy after start", busy, 1'b1);
        wait_idle("full run completes");

        // Zero mask is ignored and results are held.
        pulse_start(6'h00, 1'b0);
        repeat (5) @(negedge clk);
        chk("zero-mask start busy", busy, 1'b0);
        chk("held pass", pass, 1'b1);

        // Corrupted enc192 result.
        corrupt_idx = 2;
        pulse_start(6'h3F, 1'b1);
        wait_idle("corrupt run completes");
        corrupt_idx = 99;

        // dec256 never answered.
        silent_idx = 5;
        pulse_start(6'b100000, 1'b1);
        wait_idle("timeout run completes");
        silent_idx = 99;

        // Core answers exactly on the timeout limit cycle.
        lat = 64;
        pulse_start(6'h3F, 1'b1);
        wait_idle("limit-latency run completes");

        // Second start while busy is ignored.
        lat = 10;
        pulse_start(6'h3F, 1'b1);
        repeat (30) @(posedge clk);
        #1;
        start   = 1'b1;
        test_en = 6'h3F;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle("busy-start run completes");

        // Reset while waiting on test 2; no done may follow.
        lat = 20;
        start_q.push_back(0);
        start_q.push_back(1);
        start_q.push_back(2);
        pulse_start(6'h3F, 1'b0);
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            @(negedge clk);
            if (cif.core_start === 1'b1 && cur_test == 3'd2) found = 1;
        end
        chk("reached test 2", found, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("mid-run reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        chk("starts consumed before reset", start_q.size(), 0);
        pulse_start(6'h03, 1'b1);
        wait_idle("post-reset run completes");

        // Randomized runs against the reference model.
        for (int n = 0; n < 12; n++) begin
            int c, s;
            lat = $urandom_range(1, 64);
            c   = $urandom_range(0, 8);
            s   = $urandom_range(0, 8);
            corrupt_idx = (c > 5) ? 99 : c;
            silent_idx  = (s > 5) ? 99 : s;
            pulse_start(6'($urandom_range(1, 63)), 1'b1);
            wait_idle("random run completes");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
